seq_tx_8: RTL
=============

Name: seq_tx_8

Overview:
- Serial pattern transmitter. It is the sending end for the 8-bit sequence detector on the CAN bit path.
- Holds a loaded WIDTH-bit pattern and shifts it out one bit per clock on start, repeated rpt times with recessive gaps between frames.
- Drives the detector's din in loopback benches, and serves as the frame-bit source ahead of the CAN TX line.

Parameters:
WIDTH, 8, pattern length in bits (2..16)
GAP, 2, recessive (dout=1) idle cycles between repeated frames; 0 = back-to-back
MSB_FIRST, 1, 1 = pat[WIDTH-1] sent first, 0 = pat[0] first

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture pat into pattern register (ignored while busy)
pat  input  WIDTH  parallel pattern
start  input  1  begin transmission (ignored while busy)
rpt  input  4  number of frames to send; 0 treated as 1
dout  output  1  serial data, registered; recessive level 1
bit_valid  output  1  high on cycles where dout carries a pattern bit
busy  output  1  high from first bit until last bit/gap cycle of final frame
done  output  1  one-cycle pulse after final frame completes

Behaviour:
- Reset: asynchronous on rst_n low. dout=1, bit_valid=0, busy=0, done=0, pattern register=0, state=IDLE. Reset mid-frame aborts immediately: no done pulse, no partial resume.
- States: IDLE, SEND, GAP.
- IDLE:
  - dout=1, busy=0.
  - load=1 updates pattern register pat_r at the clock edge.
  - start=1 loads the shift register, frame counter=max(rpt,1) and bit index=0, then enters SEND.
- load and start in the same cycle: the new pat value is transmitted directly, and pat_r is also updated.
- Latency: start sampled at edge k; first bit is on dout after edge k. Bit i is on dout after edge k+i.
- SEND:
  - One bit per cycle, bit_valid=1.
  - After bit WIDTH-1, decrement the frame counter.
  - Counter remaining: go to GAP if GAP>0, else straight into SEND for the next frame with no idle cycle.
  - Counter exhausted: go to IDLE; done=1 on the first IDLE cycle.
- GAP: dout=1, bit_valid=0, busy=1 for exactly GAP cycles, then SEND with bit index 0. The same pattern is resent; pat_r changes are not picked up mid-burst.
- busy=1 throughout SEND and GAP. It drops on the same edge that raises done.
- start or load while busy: ignored entirely, with no queuing.
- Bit index width: clog2(WIDTH). The frame counter is 4 bits with no wrap (rpt max 15).
- done and busy are never high together.

Optional Feature:
- Macro SEQ_TX_STUFF_EN: CAN-style bit stuffing.
- Defined:
  - After 5 consecutive identical bits on dout within a frame, insert one complement bit with bit_valid=0.
  - The stuff bit counts as the first bit of a new run.
  - The run counter clears at each frame start and is not carried across GAP.
  - If the 5th identical bit is the frame's last bit, the stuff bit is still emitted before GAP/IDLE.
  - busy stays high through stuff bits. The frame length grows by the number of stuff bits.
- Undefined: no stuffing logic. A frame is exactly WIDTH cycles.

Test Plan:
- Basic: reset, load pat=8'b1011_0010, start, rpt=1 → dout 1,0,1,1,0,0,1,0 on 8 consecutive cycles after start edge; bit_valid=1 for those 8; done pulses once on cycle 9; dout=1 afterwards.
- Repeat and gap: pat=8'hA5, rpt=2, GAP=2 → busy high 18 cycles (8 bits, 2 ones, 8 bits), bit_valid low only in the 2 gap cycles, single done pulse. With rpt=0 → exactly one frame.
- Busy rejection: start and load with pat=8'hFF asserted mid-frame of 8'h3C → 8'h3C frame completes unchanged, no second frame, pat_r still 8'h3C.
- Reset mid-operation: rst_n low during bit 3 of 8'h0F → dout=1, busy=0, bit_valid=0 asynchronously, no done. After release, a fresh start sends full 8'h00 (pat_r reset).
- Stuffing (SEQ_TX_STUFF_EN): pat=8'hF8 → 1,1,1,1,1,0*,0,0,0 (9 cycles, bit_valid=0 on the starred stuff bit). pat=8'h00 → 0,0,0,0,0,1*,0,0,0. Without macro both are 8 cycles, no insert.
- Loopback: seq_tx_8 dout wired to the sequence detector din, with the detector loaded with the same 8-bit pattern → detector output asserts once per transmitted frame.

Source files
------------

// File: rtl/seq_tx_8.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out rpt times with recessive gaps.
// Optional CAN-style bit stuffing when SEQ_TX_STUFF_EN is defined.
module seq_tx_8 #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pat,
    input  logic             start,
    input  logic [3:0]       rpt,
    output logic             dout,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAPS = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] pat_r;
    logic [WIDTH-1:0] frame_r;
    logic [WIDTH-1:0] pat_src;
    logic [WIDTH-1:0] start_frame;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    nidx;
    logic [3:0]       frm_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             frame_last;
`ifdef SEQ_TX_STUFF_EN
    logic [2:0]       run;
`endif

    // Frame is held in transmit order so bit idx is always frame_r[idx].
    assign pat_src = load ? pat : pat_r;
    for (genvar g = 0; g < WIDTH; g++) begin : g_ord
        assign start_frame[g] = MSB_FIRST ? pat_src[WIDTH-1-g] : pat_src[g];
    end

    assign nidx       = idx + 1'b1;
    assign frame_last = (idx == IW'(WIDTH - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            frame_r <= start_frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_r     <= '0;
            idx       <= '0;
            frm_cnt   <= '0;
            gap_cnt   <= '0;
            dout      <= 1'b1;
            bit_valid <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_TX_STUFF_EN
            run       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    dout      <= 1'b1;
                    bit_valid <= 1'b0;
                    if (load)
                        pat_r <= pat;
                    if (start) begin
                        state     <= SEND;
                        idx       <= '0;
                        frm_cnt   <= (rpt == 4'd0) ? 4'd1 : rpt;
                        dout      <= start_frame[0];
                        bit_valid <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
                        run       <= 3'd1;
`endif
                    end
                end
                SEND: begin
`ifdef SEQ_TX_STUFF_EN
                    // Stuff bit takes priority, even after the frame's last bit.
                    if (run == 3'd5) begin
                        dout      <= ~dout;
                        bit_valid <= 1'b0;
                        run       <= 3'd1;
                    end else
`endif
                    if (!frame_last) begin
                        idx       <= nidx;
                        dout      <= frame_r[nidx];
                        bit_valid <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
                        run       <= (frame_r[nidx] == dout) ? run + 3'd1 : 3'd1;
`endif
                    end else if (frm_cnt == 4'd1) begin
                        state     <= IDLE;
                        dout      <= 1'b1;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        frm_cnt <= frm_cnt - 4'd1;
                        idx     <= '0;
                        if (GAP > 0) begin
                            state     <= GAPS;
                            gap_cnt   <= '0;
                            dout      <= 1'b1;
                            bit_valid <= 1'b0;
                        end else begin
                            dout      <= frame_r[0];
                            bit_valid <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
                            run       <= 3'd1;
`endif
                        end
                    end
                end
                GAPS: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state     <= SEND;
                        idx       <= '0;
                        dout      <= frame_r[0];
                        bit_valid <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
                        run       <= 3'd1;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
